// File: rtl/idv_osc_sweep_ctl.sv
// idv_osc_sweep_ctl
// Drives the IDV droop/oscillator macro. It wakes the macro, then turns on each
// oscillator in a chosen index range one at a time. For each oscillator it counts
// the rising edges of hfbankl over a fixed window of clock cycles. It hands one
// record per oscillator to the telemetry collector over a valid/ready handshake.
//
// Ports:
//   idvdebug_clki         block clock
//   idvdebug_rsti         synchronous active-high reset
//   start                 one-cycle sweep request, accepted only when idle
//   abort                 level; ends any sweep at the next clock
//   start_idx, end_idx    oscillator range 1..63, captured when start is accepted
//   enosc[62:0]           oscillator enables; bit i-1 enables oscillator i, one-hot or zero
//   sleep_b               macro wake (1 = awake)
//   hfbankl               oscillator output, asynchronous to the clock
//   res_valid, res_ready  result handshake
//   res_idx, res_cnt      oscillator index and saturating edge count of the record
//   res_sat               the count saturated
//   busy                  a sweep is in progress
//   err                   sticky bad-range flag, cleared by the next valid start
module idv_osc_sweep_ctl #(
    parameter int WAKE_CYC   = 16,
    parameter int SETTLE_CYC = 8,
    parameter int WIN_CYC    = 1024,
    parameter int CNT_W      = 16
) (
    input  logic             idvdebug_clki,
    input  logic             idvdebug_rsti,
    input  logic             start,
    input  logic             abort,
    input  logic [5:0]       start_idx,
    input  logic [5:0]       end_idx,
    output logic [62:0]      enosc,
    output logic             sleep_b,
    input  logic             hfbankl,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [5:0]       res_idx,
    output logic [CNT_W-1:0] res_cnt,
    output logic             res_sat,
    output logic             busy,
    output logic             err
);

    localparam int MAX_A   = (WAKE_CYC > SETTLE_CYC) ? WAKE_CYC : SETTLE_CYC;
    localparam int MAX_CYC = (MAX_A > WIN_CYC) ? MAX_A : WIN_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0] WAKE_LAST   = TMR_W'(WAKE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAKE   = 3'd1,
        ST_ENABLE = 3'd2,
        ST_COUNT  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    state_t           state_r;
    logic [2:0]       sync_r;
    logic             rise_s;
    logic             range_ok_s;
    logic [5:0]       cur_idx_r;
    logic [5:0]       end_idx_r;
    logic [TMR_W-1:0] tmr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             sat_nxt_s;

    // Enable pattern for one oscillator; index 1 maps to bit 0.
    function automatic logic [62:0] osc_onehot(input logic [5:0] idx);
        osc_onehot = 63'd1 << (idx - 6'd1);
    endfunction

    // Two flops resynchronise hfbankl; the third flop holds the previous value for edge detection.
    always_ff @(posedge idvdebug_clki) begin
        if (idvdebug_rsti) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], hfbankl};
        end
    end

    assign rise_s     = sync_r[1] & ~sync_r[2];
    assign range_ok_s = (start_idx != 6'd0) && (end_idx != 6'd0) && (start_idx <= end_idx);

    // Next edge count. The count stops at all-ones. The sat flag sets when the count reaches that value.
    always_comb begin
        cnt_nxt_s = cnt_r;
        sat_nxt_s = sat_r;
        if (rise_s && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == (CNT_MAX - {{(CNT_W-1){1'b0}}, 1'b1})) begin
                sat_nxt_s = 1'b1;
            end else begin
                sat_nxt_s = sat_r;
            end
        end else begin
            cnt_nxt_s = cnt_r;
            sat_nxt_s = sat_r;
        end
    end

    // Sweep state machine with all outputs registered.
    always_ff @(posedge idvdebug_clki) begin
        if (idvdebug_rsti) begin
            state_r   <= ST_IDLE;
            enosc     <= 63'd0;
            sleep_b   <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= 6'd0;
            res_cnt   <= {CNT_W{1'b0}};
            res_sat   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            cur_idx_r <= 6'd0;
            end_idx_r <= 6'd0;
            tmr_r     <= {TMR_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            sat_r     <= 1'b0;
        end else if (abort && (state_r != ST_IDLE)) begin
            // abort takes priority over a handshake in the same cycle and drops any pending record
            state_r   <= ST_IDLE;
            enosc     <= 63'd0;
            sleep_b   <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (range_ok_s) begin
                            err       <= 1'b0;
                            cur_idx_r <= start_idx;
                            end_idx_r <= end_idx;
                            tmr_r     <= {TMR_W{1'b0}};
                            sleep_b   <= 1'b1;
                            busy      <= 1'b1;
                            state_r   <= ST_WAKE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_WAKE: begin
                    if (tmr_r == WAKE_LAST) begin
                        tmr_r   <= {TMR_W{1'b0}};
                        state_r <= ST_ENABLE;
                    end else begin
                        tmr_r <= tmr_r + {{(TMR_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_ENABLE: begin
                    // The first cycle drives the enable. The settle time is counted only after enosc is high.
                    if (enosc == 63'd0) begin
                        enosc <= osc_onehot(cur_idx_r);
                        tmr_r <= {TMR_W{1'b0}};
                    end else if (tmr_r == SETTLE_LAST) begin
                        tmr_r   <= {TMR_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        sat_r   <= 1'b0;
                        state_r <= ST_COUNT;
                    end else begin
                        tmr_r <= tmr_r + {{(TMR_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_COUNT: begin
                    cnt_r <= cnt_nxt_s;
                    sat_r <= sat_nxt_s;
                    if (tmr_r == WIN_LAST) begin
                        // An edge seen in the last window cycle is still part of the record
                        res_valid <= 1'b1;
                        res_idx   <= cur_idx_r;
                        res_cnt   <= cnt_nxt_s;
                        res_sat   <= sat_nxt_s;
                        enosc     <= 63'd0;
                        state_r   <= ST_REPORT;
                    end else begin
                        tmr_r <= tmr_r + {{(TMR_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (cur_idx_r == end_idx_r) begin
                            sleep_b <= 1'b0;
                            busy    <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            cur_idx_r <= cur_idx_r + 6'd1;
                            tmr_r     <= {TMR_W{1'b0}};
                            state_r   <= ST_ENABLE;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    enosc     <= 63'd0;
                    sleep_b   <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idv_osc_sweep_ctl.sv
// Testbench for idv_osc_sweep_ctl. Instance "a" has a short window so that long
// sweeps stay quick. Instance "b" uses an 8-bit counter and the full window to
// reach saturation. hfbankl toggles at clk/4, which gives one rising edge every
// 4 clocks: 16 edges per 64-cycle window and 256 per 1024-cycle window.
module tb_idv_osc_sweep_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, b_start, abort;
    logic [5:0]  start_idx, end_idx;
    logic        hfbankl;
    logic        res_ready, b_ready;

    logic [62:0] enosc;
    logic        sleep_b, res_valid, res_sat, busy, err;
    logic [5:0]  res_idx;
    logic [15:0] res_cnt;

    logic [62:0] b_enosc;
    logic        b_sleep_b, b_res_valid, b_res_sat, b_busy, b_err;
    logic [5:0]  b_res_idx;
    logic [7:0]  b_res_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int wake_cnt = 0;
    logic [22:0] exp_q[$];

    always #5 clk = ~clk;

    initial begin
        hfbankl = 1'b0;
        #3;
        forever #20 hfbankl = ~hfbankl;
    end

    idv_osc_sweep_ctl #(.WAKE_CYC(16), .SETTLE_CYC(8), .WIN_CYC(64), .CNT_W(16)) dut_a (
        .idvdebug_clki(clk), .idvdebug_rsti(rst), .start(start), .abort(abort),
        .start_idx(start_idx), .end_idx(end_idx), .enosc(enosc), .sleep_b(sleep_b),
        .hfbankl(hfbankl), .res_valid(res_valid), .res_ready(res_ready),
        .res_idx(res_idx), .res_cnt(res_cnt), .res_sat(res_sat), .busy(busy), .err(err)
    );

    idv_osc_sweep_ctl #(.WAKE_CYC(16), .SETTLE_CYC(8), .WIN_CYC(1024), .CNT_W(8)) dut_b (
        .idvdebug_clki(clk), .idvdebug_rsti(rst), .start(b_start), .abort(abort),
        .start_idx(start_idx), .end_idx(end_idx), .enosc(b_enosc), .sleep_b(b_sleep_b),
        .hfbankl(hfbankl), .res_valid(b_res_valid), .res_ready(b_ready),
        .res_idx(b_res_idx), .res_cnt(b_res_cnt), .res_sat(b_res_sat), .busy(b_busy), .err(b_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [5:0] s, input logic [5:0] e);
        start_idx = s;
        end_idx   = e;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic push_exp(input logic [5:0] idx, input logic [15:0] cnt, input logic sat);
        exp_q.push_back({idx, cnt, sat});
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!res_valid && k < 3000) begin
            tick();
            k++;
        end
        if (!res_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_valid: timeout got res_valid=0 expected 1");
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 3000) begin
            tick();
            k++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: timeout got busy=1 expected 0");
        end
    endtask

    task automatic wait_enosc(input logic [62:0] v);
        int k = 0;
        while (enosc !== v && k < 3000) begin
            tick();
            k++;
        end
        chk("wait_enosc", {1'b0, enosc}, {1'b0, v});
    endtask

    // Monitor: scoreboard pops on every transfer, stall stability, enable invariants, wake count
    initial begin : monitor
        logic        stall_q;
        logic        sleep_q;
        logic [22:0] held;
        logic [22:0] got;
        logic [22:0] want;
        stall_q = 1'b0;
        sleep_q = 1'b0;
        held    = 23'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 1'b0;
                sleep_q = 1'b0;
            end else begin
                got = {res_idx, res_cnt, res_sat};
                n_cmp++;
                if (((enosc & (enosc - 63'd1)) != 63'd0) || ((enosc != 63'd0) && !sleep_b)) begin
                    n_err++;
                    $display("FAIL invariant: got enosc=%0h sleep_b=%0b expected one-hot with sleep_b=1", enosc, sleep_b);
                end
                if (stall_q && res_valid) chk("stall_stable", {41'd0, got}, {41'd0, held});
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_unexpected: got record %0h expected none", got);
                    end else begin
                        want = exp_q.pop_front();
                        chk("sb_record", {41'd0, got}, {41'd0, want});
                    end
                end
                if (sleep_b && !sleep_q) wake_cnt++;
                stall_q = res_valid && !res_ready;
                held    = got;
                sleep_q = sleep_b;
            end
        end
    end

    initial begin : stim
        int k;
        rst = 1'b1; start = 1'b0; b_start = 1'b0; abort = 1'b0;
        start_idx = 6'd0; end_idx = 6'd0; res_ready = 1'b1; b_ready = 1'b1;
        repeat (3) tick();
        // reset values
        chk("rst_enosc", {1'b0, enosc}, 64'd0);
        chk("rst_sleep_b", {63'd0, sleep_b}, 64'd0);
        chk("rst_res", {41'd0, res_valid, res_idx, res_cnt}, 64'd0);
        chk("rst_flags", {61'd0, res_sat, busy, err}, 64'd0);
        rst = 1'b0;
        tick();

        // single oscillator 5..5
        push_exp(6'd5, 16'd16, 1'b0);
        pulse_start(6'd5, 6'd5);
        chk("single_busy", {62'd0, busy, sleep_b}, 64'd3);
        chk("single_wake_enosc", {1'b0, enosc}, 64'd0);
        wait_enosc(63'h10);
        wait_idle();
        chk("single_end", {61'd0, busy, sleep_b, res_valid}, 64'd0);
        chk("single_end_enosc", {1'b0, enosc}, 64'd0);

        // bad ranges, then a valid start clears err
        tick();
        pulse_start(6'd10, 6'd3);
        chk("bad_hi_lo", {61'd0, err, busy, sleep_b}, 64'd4);
        chk("bad_hi_lo_enosc", {1'b0, enosc}, 64'd0);
        tick();
        pulse_start(6'd0, 6'd5);
        chk("bad_zero", {61'd0, err, busy, sleep_b}, 64'd4);
        push_exp(6'd2, 16'd16, 1'b0);
        pulse_start(6'd2, 6'd2);
        chk("good_clears_err", {62'd0, err, busy}, 64'd1);
        wait_idle();

        // full sweep 1..63 with 10 stall cycles per record
        tick();
        res_ready = 1'b0;
        wake_cnt  = 0;
        for (int i = 1; i <= 63; i++) push_exp(6'(i), 16'd16, 1'b0);
        pulse_start(6'd1, 6'd63);
        for (int i = 1; i <= 63; i++) begin
            wait_valid();
            repeat (10) tick();
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        tick();
        chk("sweep_end", {62'd0, busy, sleep_b}, 64'd0);
        chk("sweep_wake_once", 64'(wake_cnt), 64'd1);
        chk("sweep_sb_drained", 64'(exp_q.size()), 64'd0);

        // abort during COUNT of idx 7 in a 3..9 sweep
        res_ready = 1'b1;
        for (int i = 3; i <= 6; i++) push_exp(6'(i), 16'd16, 1'b0);
        pulse_start(6'd3, 6'd9);
        wait_enosc(63'h40);
        repeat (20) tick();
        chk("abort_pre_enosc", {1'b0, enosc}, 64'h40);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_enosc", {1'b0, enosc}, 64'd0);
        chk("abort_outs", {61'd0, sleep_b, res_valid, busy}, 64'd0);
        push_exp(6'd1, 16'd16, 1'b0);
        pulse_start(6'd1, 6'd1);
        chk("restart_wake", {62'd0, busy, sleep_b}, 64'd3);
        repeat (10) tick();
        chk("restart_wake_enosc", {1'b0, enosc}, 64'd0);
        wait_enosc(63'h1);
        wait_idle();

        // start while busy is ignored; reset asserted while a record is pending
        tick();
        res_ready = 1'b0;
        push_exp(6'd4, 16'd16, 1'b0);
        pulse_start(6'd4, 6'd5);
        repeat (5) tick();
        pulse_start(6'd20, 6'd20);
        wait_valid();
        chk("busy_start_idx", {58'd0, res_idx}, 64'd4);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        wait_valid();
        chk("busy_start_idx2", {58'd0, res_idx}, 64'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_enosc", {1'b0, enosc}, 64'd0);
        chk("midrst_res", {41'd0, res_valid, res_idx, res_cnt}, 64'd0);
        chk("midrst_flags", {60'd0, res_sat, busy, err, sleep_b}, 64'd0);

        // saturation with an 8-bit counter and a 1024-cycle window
        tick();
        start_idx = 6'd1;
        end_idx   = 6'd1;
        b_start   = 1'b1;
        tick();
        b_start   = 1'b0;
        k = 0;
        while (!b_res_valid && k < 3000) begin
            tick();
            k++;
        end
        chk("sat_valid", {63'd0, b_res_valid}, 64'd1);
        chk("sat_cnt", {56'd0, b_res_cnt}, 64'd255);
        chk("sat_flag", {63'd0, b_res_sat}, 64'd1);
        chk("sat_idx", {58'd0, b_res_idx}, 64'd1);
        tick();
        tick();
        chk("sat_done", {62'd0, b_busy, b_sleep_b}, 64'd0);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/idv_osc_sweep_ctl.md
Name: idv_osc_sweep_ctl

Overview:
- Controller on the driving side of the IDV droop/oscillator macro.
- Sequences the macro's 63 oscillator enables (enosc[63:1]) one at a time and manages sleep_b.
- Counts rising edges of the macro's hfbankl output over a fixed window of idvdebug_clki cycles.
- Returns one count record per oscillator over a valid/ready handshake to the debug/telemetry collector.

Parameters:
- WAKE_CYC, 16: cycles sleep_b is held high before the first enable.
- SETTLE_CYC, 8: cycles after an enosc bit asserts before counting starts.
- WIN_CYC, 1024: measurement window length in clocks (≥1).
- CNT_W, 16: width of the edge counter and of the result count.

Ports:
- idvdebug_clki, in, 1: block clock.
- idvdebug_rsti, in, 1: reset, synchronous, active-high.
- start, in, 1: one-cycle pulse; begins a sweep (ignored unless IDLE).
- abort, in, 1: level; ends the sweep at the next clock.
- start_idx, in, 6: first oscillator index (1..63), sampled on start.
- end_idx, in, 6: last oscillator index (1..63), sampled on start.
- enosc, out, 63: oscillator enables, bit i-1 = oscillator i, one-hot or zero.
- sleep_b, out, 1: macro wake (1 = awake).
- hfbankl, in, 1: oscillator output, asynchronous to idvdebug_clki.
- res_valid, out, 1: result record valid.
- res_ready, in, 1: collector accepts the record.
- res_idx, out, 6: oscillator index of the record.
- res_cnt, out, CNT_W: rising-edge count, saturating.
- res_sat, out, 1: count saturated.
- busy, out, 1: sweep in progress (state ≠ IDLE).
- err, out, 1: sticky bad-range flag; cleared by the next valid start.

Behaviour:
- Reset values: enosc=0, sleep_b=0, res_valid=0, res_idx=0, res_cnt=0, res_sat=0, busy=0, err=0; FSM in IDLE.
- Synchroniser: hfbankl passes through a 2-flop synchroniser, then a third flop for edge detection.
  - A rising edge is sync2 & ~sync3.
  - Synchroniser flops reset to 0.
  - Edge-to-count latency is 3 clocks.
- Range check on start:
  - start_idx=0, end_idx=0, or start_idx>end_idx → err=1, stay IDLE, no outputs change.
  - Otherwise err=0 and cur_idx=start_idx.
- IDLE → WAKE on a valid start.
- WAKE:
  - sleep_b=1, enosc=0.
  - Counter runs WAKE_CYC cycles, then → ENABLE.
- ENABLE:
  - enosc[cur_idx-1]=1, all other bits 0.
  - Wait SETTLE_CYC cycles, clear edge counter, → COUNT.
- COUNT:
  - Exactly WIN_CYC clocks; each synchronised rising edge increments the counter.
  - The counter saturates at 2^CNT_W-1 and sets the sat bit; it never wraps.
  - Edges detected in the cycle after the window ends are not counted.
  - Then → REPORT.
- REPORT:
  - enosc=0 in the first REPORT cycle.
  - res_valid=1, with res_idx/res_cnt/res_sat held stable until res_valid&res_ready.
  - res_valid may not drop without a transfer, except on abort or reset.
- After the transfer:
  - If cur_idx==end_idx → IDLE, with sleep_b=0 in the same cycle the transfer completes.
  - Else cur_idx+1 → ENABLE (no re-wake).
- res_valid rises 1 cycle after the window ends.
- Minimum per-oscillator period is SETTLE_CYC+WIN_CYC+2 cycles with res_ready held high.
- start while busy is ignored; start_idx/end_idx are not re-sampled.
- abort (any non-IDLE state):
  - Next clock: IDLE, enosc=0, sleep_b=0, res_valid=0.
  - A pending record is dropped.
  - abort in IDLE has no effect.
  - abort wins over a simultaneous res_ready.
- Reset mid-sweep returns all outputs to their reset values on the next clock edge, regardless of state.
- Invariants: enosc is never multi-hot; enosc≠0 implies sleep_b=1.
- start_idx==end_idx is legal: exactly one record is produced.

Test Plan:
- Single oscillator: start_idx=5, end_idx=5, hfbankl toggling at clk/4, WIN_CYC=1024 → enosc=0x10 during ENABLE/COUNT; one record with res_idx=5, res_cnt=256±1, res_sat=0; sleep_b drops after the transfer; busy=0.
- Full sweep with backpressure: start 1..63, res_ready held low 10 cycles per record → 63 records with idx 1..63 in order; each record stable while stalled; enosc one-hot throughout; WAKE occurs only once.
- Saturation: CNT_W=8, hfbankl at clk/4, WIN_CYC=1024 → res_cnt=255, res_sat=1.
- Bad range: start_idx=10, end_idx=3, then start_idx=0 → err=1, busy stays 0, enosc=0; a following valid start 2..2 clears err.
- Abort during COUNT of idx 7 in a 3..9 sweep → next cycle enosc=0, sleep_b=0, res_valid=0, IDLE; a new start runs cleanly from WAKE.
- Reset asserted in REPORT with res_valid=1 → all outputs at reset values next cycle; start pulsed while busy has no effect (idx unchanged).
